// File: rtl/apb_i2c_master_sequencer.sv
// apb_i2c_master_sequencer: round-robin APB master that feeds two
// requesters into the APB-I2C bridge with a bounded PREADY wait.
module apb_i2c_master_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             cmd_write;
  logic             cmd_id;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic             last_id;
  logic [CNT_W-1:0] cnt;
  logic             gnt_id;
  logic             accept;
  logic             tmo_hit;

  // Conflict goes to whoever was not granted last.
  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    tmo_hit    = 1'b0;
    if (req0_valid && req1_valid)
      gnt_id = ~last_id;
    else
      gnt_id = req1_valid;
    unique case (state)
      IDLE: begin
        if (PRESETn && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_nx   = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_nx = RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cmd_write   <= 1'b0;
      cmd_id      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      last_id     <= 1'b1;
      cnt         <= '0;
      rsp_id      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd_write <= gnt_id ? req1_write : req0_write;
        cmd_addr  <= gnt_id ? req1_addr : req0_addr;
        cmd_wdata <= gnt_id ? req1_wdata : req0_wdata;
        cmd_id    <= gnt_id;
        last_id   <= gnt_id;
      end
      if (state == SETUP)
        cnt <= '0;
      else if (state == ACCESS && !PREADY && !tmo_hit)
        cnt <= cnt + 1'b1;
      if (state == ACCESS && PREADY) begin
        rsp_id      <= cmd_id;
        rsp_rdata   <= cmd_write ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (tmo_hit) begin
        rsp_id      <= cmd_id;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign PSELx     = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign PWRITE    = cmd_write;
  assign PADDR     = cmd_addr;
  assign PWDATA    = cmd_wdata;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_apb_i2c_master_sequencer.sv
// Bench for apb_i2c_master_sequencer: transaction-timeline model,
// directed literal cases and randomized traffic.
module tb_apb_i2c_master_sequencer;
  localparam int T = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_write = 1'b0, req1_write = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  apb_i2c_master_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: one transaction timeline relative to its acceptance cycle.
  int          ncyc = 0;
  int          t0 = 0;
  int          len = 0;
  int          nwait = 0;
  bit          active = 0;
  bit          c_tmo = 0;
  logic        c_write = 0, c_id = 0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        last_g = 1'b1;
  logic        lr_id = 0, lr_err = 0, lr_tmo = 0;
  logic [31:0] lr_rdata = '0;
  logic [31:0] drv_prdata = '0;
  logic        drv_err = 0;
  int          f_nwait = -1;
  int          f_slverr = -1;
  bit          f_prdata_en = 0;
  logic [31:0] f_prdata = '0;
  bit          acc_flag [2];
  bit          rsp_flag = 0;
  int          acc_cyc = 0, rsp_cyc = 0, pen_cnt = 0;
  int          acc_log_id [$];
  int          acc_log_cyc [$];

  int          k;
  bit          e_psel, e_pen, e_rv, e_busy, e_r0, e_r1;
  logic [31:0] e_rdata;
  logic        e_err, e_tmo;

  function automatic int pick_nwait();
    if (f_nwait >= 0) return f_nwait;
    case ($urandom % 6)
      0: return 0;
      1: return 1;
      2: return T - 1;
      3: return T;
      default: return $urandom_range(0, T);
    endcase
  endfunction

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      chk("rst_psel", 32'(PSELx), 0);
      chk("rst_penable", 32'(PENABLE), 0);
      chk("rst_pwrite", 32'(PWRITE), 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_rsp_tmo", 32'(rsp_timeout), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      active = 0;
      last_g = 1'b1;
      lr_id = 0; lr_err = 0; lr_tmo = 0; lr_rdata = '0;
    end else begin
      if (active && (ncyc - t0 > 2 + len)) active = 0;
      k = ncyc - t0;
      e_psel = active && k >= 1 && k <= 1 + len;
      e_pen  = active && k >= 2 && k <= 1 + len;
      e_rv   = active && k == 2 + len;
      e_busy = active && k >= 1;
      e_r0 = !active && req0_valid && (!req1_valid || last_g);
      e_r1 = !active && req1_valid && (!req0_valid || !last_g);
      chk("psel", 32'(PSELx), 32'(e_psel));
      chk("penable", 32'(PENABLE), 32'(e_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ready0", 32'(req0_ready), 32'(e_r0));
      chk("ready1", 32'(req1_ready), 32'(e_r1));
      if (e_psel) begin
        chk("paddr", PADDR, c_addr);
        chk("pwdata", PWDATA, c_wdata);
        chk("pwrite", 32'(PWRITE), 32'(c_write));
      end
      if (PENABLE) pen_cnt++;
      if (e_rv) begin
        if (c_tmo) begin
          e_rdata = '0; e_err = 1; e_tmo = 1;
        end else begin
          e_rdata = c_write ? 32'h0 : drv_prdata;
          e_err = drv_err; e_tmo = 0;
        end
        lr_id = c_id; lr_rdata = e_rdata;
        lr_err = e_err; lr_tmo = e_tmo;
        rsp_flag = 1;
        rsp_cyc = ncyc;
      end
      chk("rsp_id", 32'(rsp_id), 32'(lr_id));
      chk("rsp_rdata", rsp_rdata, lr_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(lr_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(lr_tmo));
      if (e_r0 || e_r1) begin
        c_id    = e_r1;
        c_write = e_r1 ? req1_write : req0_write;
        c_addr  = e_r1 ? req1_addr : req0_addr;
        c_wdata = e_r1 ? req1_wdata : req0_wdata;
        last_g  = e_r1;
        active  = 1;
        t0      = ncyc;
        nwait   = pick_nwait();
        c_tmo   = nwait >= T;
        len     = c_tmo ? T : nwait + 1;
        acc_flag[e_r1] = 1;
        acc_cyc = ncyc;
        pen_cnt = 0;
        acc_log_id.push_back(int'(e_r1));
        acc_log_cyc.push_back(ncyc);
      end
    end
    ncyc++;
  end

  // Slave: PREADY low until the planned wait count, noise elsewhere.
  task automatic step();
    int kk;
    @(posedge PCLK);
    #1;
    PREADY  = 1'($urandom % 2);
    PSLVERR = 1'($urandom % 2);
    PRDATA  = $urandom;
    kk = ncyc - t0;
    if (active && kk >= 2 && kk <= 1 + len) begin
      if (kk - 2 == nwait) begin
        PREADY = 1'b1;
        if (f_prdata_en) PRDATA = f_prdata;
        if (f_slverr >= 0) PSLVERR = f_slverr[0];
        drv_prdata = PRDATA;
        drv_err = PSLVERR;
      end else begin
        PREADY = 1'b0;
      end
    end
  endtask

  task automatic issue(input bit id, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input int nw);
    bit ok;
    f_nwait = nw;
    rsp_flag = 0;
    acc_flag[0] = 0;
    acc_flag[1] = 0;
    step();
    if (id) begin
      req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      ok = acc_flag[id];
    end
    chk("accept_bound", 32'(ok), 1);
    req0_valid = 0;
    req1_valid = 0;
    acc_flag[id] = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = rsp_flag;
    end
    chk("rsp_bound", 32'(ok), 1);
  endtask

  task automatic rand_reqs();
    if (acc_flag[0]) begin acc_flag[0] = 0; req0_valid = 0; end
    if (acc_flag[1]) begin acc_flag[1] = 0; req1_valid = 0; end
    if (!req0_valid && $urandom % 3 == 0) begin
      req0_valid = 1; req0_write = 1'($urandom % 2);
      req0_addr = $urandom; req0_wdata = $urandom;
    end
    if (!req1_valid && $urandom % 3 == 0) begin
      req1_valid = 1; req1_write = 1'($urandom % 2);
      req1_addr = $urandom; req1_wdata = $urandom;
    end
  endtask

  initial begin
    bit ok;
    #1;
    PRESETn = 0;
    req0_valid = 1;
    req0_addr = 32'h8;
    repeat (3) step();
    req0_valid = 0;
    PRESETn = 1;

    f_slverr = 0;
    issue(0, 1'b1, 32'h8, 32'h0000_1234, 0);
    chk("zw_latency", 32'(rsp_cyc - acc_cyc), 3);
    chk("zw_pen_cycles", 32'(pen_cnt), 1);
    chk("zw_rsp_id", 32'(rsp_id), 0);
    chk("zw_rsp_rdata", rsp_rdata, 0);
    chk("zw_rsp_err", 32'(rsp_err), 0);

    f_prdata_en = 1;
    f_prdata = 32'hA5A5_0001;
    issue(1, 1'b0, 32'h4, 32'h0, 3);
    f_prdata_en = 0;
    chk("ws_latency", 32'(rsp_cyc - acc_cyc), 6);
    chk("ws_pen_cycles", 32'(pen_cnt), 4);
    chk("ws_rsp_id", 32'(rsp_id), 1);
    chk("ws_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("ws_rsp_err", 32'(rsp_err), 0);

    issue(0, 1'b1, 32'h0, 32'hDEAD_BEEF, T);
    chk("to_latency", 32'(rsp_cyc - acc_cyc), 18);
    chk("to_pen_cycles", 32'(pen_cnt), 16);
    chk("to_rsp_err", 32'(rsp_err), 1);
    chk("to_rsp_tmo", 32'(rsp_timeout), 1);
    chk("to_rsp_rdata", rsp_rdata, 0);

    issue(1, 1'b1, 32'h0, 32'h5, T - 1);
    chk("last_latency", 32'(rsp_cyc - acc_cyc), 18);
    chk("last_pen_cycles", 32'(pen_cnt), 16);
    chk("last_rsp_tmo", 32'(rsp_timeout), 0);
    chk("last_rsp_err", 32'(rsp_err), 0);

    f_slverr = 1;
    issue(0, 1'b0, 32'h20, 32'h0, 0);
    chk("se_rsp_err", 32'(rsp_err), 1);
    chk("se_rsp_tmo", 32'(rsp_timeout), 0);
    f_slverr = -1;

    PRESETn = 0;
    step();
    f_nwait = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 32'h100;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h200;
    acc_log_id.delete();
    acc_log_cyc.delete();
    step();
    PRESETn = 1;
    for (int i = 0; i < 40 && acc_log_id.size() < 4; i++) step();
    req0_valid = 0;
    req1_valid = 0;
    chk("arb_count", 32'(acc_log_id.size()), 4);
    for (int i = 0; i < acc_log_id.size() && i < 4; i++) begin
      chk("arb_id", 32'(acc_log_id[i]), 32'(i % 2));
      if (i > 0)
        chk("arb_gap", 32'(acc_log_cyc[i] - acc_log_cyc[i-1]), 4);
    end

    acc_flag[0] = 0;
    acc_flag[1] = 0;
    f_nwait = -1;
    repeat (2000) begin
      step();
      rand_reqs();
    end
    req0_valid = 0;
    req1_valid = 0;
    repeat (30) step();

    f_nwait = T;
    acc_flag[0] = 0;
    step();
    req0_valid = 1; req0_write = 1; req0_addr = 32'h10;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      ok = acc_flag[0];
    end
    chk("mr_accept", 32'(ok), 1);
    req0_valid = 0;
    repeat (3) step();
    chk("mr_pre_penable", 32'(PENABLE), 1);
    rsp_flag = 0;
    PRESETn = 0;
    #1;
    chk("mr_psel_drop", 32'(PSELx), 0);
    chk("mr_penable_drop", 32'(PENABLE), 0);
    repeat (2) step();
    PRESETn = 1;
    repeat (30) step();
    chk("mr_no_rsp", 32'(rsp_flag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_i2c_master_sequencer.md
# apb_i2c_master_sequencer

APB master that sequences register accesses into the APB–I2C bridge on behalf of two internal requesters (e.g. a DMA-style TX feeder and a config/status poller). It round-robin arbitrates the requesters and drives the APB SETUP/ACCESS protocol. It waits on PREADY with a bounded timeout, because the bridge does not assert PREADY for every address. It returns one registered response per command.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles before forced completion; legal range is 1 or more.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter.

Ports:
- PCLK  in  1  clock; the block uses this single clock only.
- PRESETn  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  the requester has a command pending.
- req0_write / req1_write  in  1  1 = APB write, 0 = APB read.
- req0_addr / req1_addr  in  32  APB address.
- req0_wdata / req1_wdata  in  32  write data.
- req0_ready / req1_ready  out  1  command accepted this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester that owns the response.
- rsp_rdata  out  32  PRDATA captured for a read; 0 for a write or a timeout.
- rsp_err  out  1  PSLVERR, or timeout.
- rsp_timeout  out  1  completion was forced by timeout.
- busy  out  1  FSM not in IDLE.
- PSELx, PENABLE, PWRITE  out  1  APB master controls.
- PADDR, PWDATA  out  32  APB master address and write data.
- PRDATA  in  32  APB read data.
- PREADY, PSLVERR  in  1  APB slave handshake.

## Operation
- FSM states: IDLE → SETUP → ACCESS → RESP → IDLE.
- IDLE:
  - If any req*_valid is high, grant one requester and assert its req*_ready combinationally in the same cycle; acceptance = valid && ready.
  - Latch write, addr and wdata into the command register, record the grant id, then go to SETUP.
- Arbitration is round-robin:
  - On a conflict, the requester not granted last wins.
  - After reset, requester 0 has priority.
  - A lone requester is always granted.
- SETUP: PSELx=1, PENABLE=0, PADDR/PWDATA/PWRITE come from the command register. Clear the wait counter.
- ACCESS: PSELx=1, PENABLE=1, address, data and control held stable.
  - PREADY=1: capture PRDATA (reads only; writes give 0) and PSLVERR into the response registers, then go to RESP.
  - PREADY=0 and counter = TIMEOUT_CYCLES-1: timeout. Set rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to RESP.
  - Otherwise the counter increments.
  - PREADY in the final allowed cycle takes precedence over timeout.
- RESP: rsp_valid=1 for exactly one cycle. PSELx=PENABLE=0. Return to IDLE.
- rsp_id, rsp_rdata, rsp_err and rsp_timeout are registered and hold until the next RESP.
- Requests are never accepted outside IDLE; req*_ready is 0 in every other state.
- busy=1 in SETUP, ACCESS and RESP.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - All outputs are 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_*, busy, req*_ready.
  - Last-grant pointer selects requester 0 next.
- Reset in mid-transaction: the APB outputs drop at once, the in-flight command is discarded and no response is issued.
- Latency, with acceptance at cycle 0: SETUP at cycle 1, ACCESS from cycle 2, rsp_valid at cycle 2+N+1, where N = the number of PREADY=0 ACCESS cycles.
  - Zero-wait case: rsp_valid at cycle 3.
  - Worst case: ACCESS lasts TIMEOUT_CYCLES cycles.
- Back-to-back: the next acceptance can occur in the cycle after RESP, so peak throughput is 1 command per 4 cycles.
- APB outputs change only on PCLK rising edges, and PADDR/PWDATA/PWRITE are stable from SETUP through the end of ACCESS.
- PREADY and PSLVERR are sampled only while PENABLE=1. Values in SETUP, RESP or IDLE are ignored.

## Test plan
- Reset: pulse PRESETn low with req0_valid=1 → all outputs 0 during reset; first grant afterwards goes to requester 0.
- Zero-wait write: req0 write to addr 8 with wdata 0x0000_1234, PREADY=1 throughout ACCESS.
  - PSELx rises at cycle 1 and PENABLE at cycle 2.
  - rsp_valid at cycle 3 with rsp_id=0, rsp_err=0, rsp_rdata=0.
- Wait-state read: req1 read of addr 4; PREADY goes high on the 4th ACCESS cycle with PRDATA=0xA5A5_0001.
  - PENABLE is high for 4 cycles.
  - Response: rsp_id=1, rsp_rdata=0xA5A5_0001, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=16, write to addr 0 with PREADY held 0.
  - ACCESS lasts exactly 16 cycles.
  - Response: rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with PREADY=1 on the 16th cycle → rsp_timeout=0.
- Arbitration: req0 and req1 valid continuously from reset → grant order 0,1,0,1; each accepted 4 cycles apart; PADDR matches the granted requester.
- Slave error and reset mid-ACCESS:
  - PREADY=1 with PSLVERR=1 → rsp_err=1, rsp_timeout=0.
  - Assert PRESETn low during ACCESS → PSELx and PENABLE drop immediately and no rsp_valid is produced.
